serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

- Bit-serial adder controller: sequences a single one-bit full-adder cell (the `fa_ha` cell: `a`, `b`, `c` → `sum`, `carry`) over a `WIDTH`-bit operand pair, one bit per clock, LSB first.
- Sits between a requester issuing start/operand pairs and the shared full-adder datapath.
- Handles operand capture, carry feedback, bit counting, result assembly and the start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits. Must be ≥ 2.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request a new addition; sampled on the rising edge.
- `op_a` input `WIDTH`: addend A; captured on the accepted `start`.
- `op_b` input `WIDTH`: addend B; captured on the accepted `start`.
- `cin` input 1: carry-in; captured on the accepted `start`.
- `busy` output 1: high while bits are being processed (state `RUN`).
- `done` output 1: one-cycle pulse; `result` and `cout` are valid.
- `result` output `WIDTH`: sum, registered; held until the next completion.
- `cout` output 1: final carry-out; registered and held like `result`.

## Operation
- The FSM has three states: `IDLE`, `RUN`, `DONE`.
- **`IDLE`:**
  - `busy`=0, `done`=0.
  - When `start`=1: load the A/B shift registers from `op_a`/`op_b`, load the carry flop from `cin`, clear the bit counter, and go to `RUN`.
- **`RUN`:** each cycle:
  - Drive the cell with `a`=A[0], `b`=B[0], `c`=carry flop.
  - Shift the cell `sum` into the MSB of the internal sum register (right shift).
  - Shift A and B right by one.
  - Load the carry flop with the cell `carry`.
  - Increment the counter.
  - When the counter equals `WIDTH-1` at this edge, also copy the completed sum register into `result`, copy the new carry into `cout`, and go to `DONE`.
- **`DONE`:**
  - `done`=1 for exactly this cycle.
  - `start`=1 here is accepted exactly as in `IDLE` (back-to-back operation, next state `RUN`). Otherwise go to `IDLE`.
- `start` during `RUN` is ignored; operands in flight are unaffected.
- Arithmetic: `{cout, result}` = `op_a` + `op_b` + `cin`, modulo 2^(`WIDTH`+1). No overflow flag.
- `result`/`cout` change only on the `RUN`→`DONE` edge. Intermediate bits are never visible on `result`.
- **Reset:** on `rst`=1 at any edge, including mid-`RUN`:
  - state ← `IDLE`, counter ← 0, carry flop ← 0, shift registers ← 0.
  - Outputs: `busy`=0, `done`=0, `result`=0, `cout`=0.
  - An in-flight operation is discarded.
  - `rst` has priority over `start`.

## Timing
- Edge 0 samples `start`=1 in `IDLE`/`DONE`: `busy` rises after edge 0.
- Edges 1..`WIDTH` process bits 0..`WIDTH-1`: `busy`=1 for exactly `WIDTH` cycles.
- After edge `WIDTH`: `busy`=0, `done`=1, and `result`/`cout` are updated.
- Latency from the accepting edge to `done`: `WIDTH` cycles.
- Throughput with `start` held high: one result per `WIDTH`+1 cycles.
- `busy` and `done` are never high together.
- The cell is purely combinational. The carry path is one cell delay from the carry flop back to the carry flop.

## Configuration
- **Macro:** `SERIAL_ADDER_SUB_EN`.
- **Defined:**
  - Adds input port `sub` (1 bit), captured with the operands.
  - When `sub`=1 at capture: B is loaded as `~op_b`, the carry flop is loaded with 1, and `cin` is ignored.
  - Result: `result` = `op_a` − `op_b` mod 2^`WIDTH`; `cout`=1 means no borrow.
  - When `sub`=0: identical to plain addition.
- **Undefined:** no `sub` port; addition only as described above.

## Test plan
All scenarios use `WIDTH`=8.
- **Addition:** `op_a`=0x5A, `op_b`=0x33, `cin`=0 → after 8 `busy` cycles, `done` pulses with `result`=0x8D, `cout`=0.
- **Carry chain:** 0xFF+0x01, `cin`=0 → `result`=0x00, `cout`=1. Then 0xFF+0xFF, `cin`=1 → `result`=0xFF, `cout`=1.
- **Busy/back-to-back:**
  - Pulse `start` with 0x01+0x01 during `RUN` → ignored; the first result is unchanged.
  - Hold `start` in `DONE` → `busy` is 1 on the cycle after `done`, and the second result arrives 9 cycles after the first.
- **Hold:** after `done`, with `start`=0 for 20 cycles → `result`/`cout` stay constant and `busy`=`done`=0.
- **Reset mid-operation:** assert `rst` at bit 4 of 0xAA+0x55 → next cycle all outputs are 0 and the state is `IDLE`. Then a fresh 0x0F+0x01 → `result`=0x10, `cout`=0 after 8 cycles.
- **Subtraction, `SERIAL_ADDER_SUB_EN` defined:**
  - 0x10−0x01 → `result`=0x0F, `cout`=1.
  - 0x01−0x02 → `result`=0xFF, `cout`=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_ctrl (with leaf cell fa_ha)
// Brief    : Bit-serial adder controller, one full-adder cell, LSB first.
//            Optional macro SERIAL_ADDER_SUB_EN adds a 'sub' port (A - B).
// Revision : 1.0
// ============================================================================

module fa_ha (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int                 c_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [WIDTH-1:0]   sum_q,    sum_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [c_CNT_W-1:0] cnt_q,    cnt_d;
    logic               carry_q,  carry_d;
    logic               cout_q,   cout_d;

    logic               w_cell_sum;
    logic               w_cell_carry;
    logic [WIDTH-1:0]   w_sum_shifted;

    fa_ha u_cell (
        .a     (a_q[0]),
        .b     (b_q[0]),
        .c     (carry_q),
        .sum   (w_cell_sum),
        .carry (w_cell_carry)
    );

    assign w_sum_shifted = {w_cell_sum, sum_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sum_d    = sum_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d   = op_a;
                    sum_d = '0;
                    cnt_d = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    // Two's-complement subtraction: A + ~B + 1, cin unused.
                    if (sub) begin
                        b_d     = ~op_b;
                        carry_d = 1'b1;
                    end else begin
                        b_d     = op_b;
                        carry_d = cin;
                    end
`else
                    b_d     = op_b;
                    carry_d = cin;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = w_sum_shifted;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = w_cell_carry;
                cnt_d   = cnt_q + c_CNT_W'(1);
                if (cnt_q == c_CNT_LAST) begin
                    result_d = w_sum_shifted;
                    cout_d   = w_cell_carry;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
        end
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule

`default_nettype wire
